// File: rtl/io_port_pkg.sv
// Shared widths and the output-queue entry layout for the I/O port unit.
package io_port_pkg;

    localparam int DATA_W         = 16;
    localparam int PORT_ADDR_W    = 4;
    localparam int NUM_PORTS      = 16;
    localparam int OUT_FIFO_DEPTH = 4;
    localparam int OUT_CNT_W      = $clog2(OUT_FIFO_DEPTH) + 1;

    // One queued OUT: port number in the upper bits, data below.
    typedef struct packed {
        logic [PORT_ADDR_W-1:0] port;
        logic [DATA_W-1:0]      data;
    } out_entry_t;

    localparam int OUT_ENTRY_W = $bits(out_entry_t);

endpackage

// File: rtl/io_port_if.sv
// CPU-side port bus plus external producer/consumer handshakes.
interface io_port_if
    import io_port_pkg::*;
#(
    parameter int DW        = io_port_pkg::DATA_W,
    parameter int AW        = io_port_pkg::PORT_ADDR_W,
    parameter int NPORTS    = io_port_pkg::NUM_PORTS,
    parameter int CNT_W     = io_port_pkg::OUT_CNT_W
);
    logic              port_write;
    logic              port_read;
    logic [AW-1:0]     port_addr;
    logic [DW-1:0]     port_wdata;
    logic [DW-1:0]     port_rdata;
    logic              port_stall;
    logic [NPORTS-1:0] in_fresh;
    logic              ext_out_valid;
    logic [AW-1:0]     ext_out_port;
    logic [DW-1:0]     ext_out_data;
    logic              ext_out_ready;
    logic              ext_in_valid;
    logic [AW-1:0]     ext_in_port;
    logic [DW-1:0]     ext_in_data;
    logic [CNT_W-1:0]  out_count;

    modport slave (
        input  port_write, port_read, port_addr, port_wdata,
        input  ext_out_ready, ext_in_valid, ext_in_port, ext_in_data,
        output port_rdata, port_stall, in_fresh,
        output ext_out_valid, ext_out_port, ext_out_data, out_count
    );

    modport master (
        output port_write, port_read, port_addr, port_wdata,
        output ext_out_ready, ext_in_valid, ext_in_port, ext_in_data,
        input  port_rdata, port_stall, in_fresh,
        input  ext_out_valid, ext_out_port, ext_out_data, out_count
    );

endinterface

// File: rtl/port_out_fifo.sv
// Small synchronous FIFO with async active-low reset; head reads as zero when empty.
module port_out_fifo
    import io_port_pkg::*;
#(
    parameter int WIDTH = io_port_pkg::OUT_ENTRY_W,
    parameter int DEPTH = io_port_pkg::OUT_FIFO_DEPTH,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Storage is not reset; the head is masked to zero while empty instead.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/io_port_unit.sv
// Device-side responder for CPU IN/OUT: queued OUT path to an external
// consumer, and a 16-entry input register file filled by an external producer.
module io_port_unit #(
    parameter int DATA_W         = io_port_pkg::DATA_W,
    parameter int PORT_ADDR_W    = io_port_pkg::PORT_ADDR_W,
    parameter int OUT_FIFO_DEPTH = io_port_pkg::OUT_FIFO_DEPTH
) (
    input logic      clk,
    input logic      reset,
    io_port_if.slave bus
);
    import io_port_pkg::*;

    localparam int NPORTS  = 2 ** PORT_ADDR_W;
    localparam int ENTRY_W = PORT_ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(OUT_FIFO_DEPTH) + 1;

    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_head;
    logic [CNT_W-1:0]   fifo_count;

    logic [DATA_W-1:0]  in_reg [NPORTS];
    logic [NPORTS-1:0]  fresh;

    // OUT path: the FIFO gates push with full and pop with empty itself.
    port_out_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (OUT_FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_out_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (bus.port_write),
        .push_data ({bus.port_addr, bus.port_wdata}),
        .pop       (bus.ext_out_ready),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bus.port_stall    = bus.port_write & fifo_full;
    assign bus.ext_out_valid = ~fifo_empty;
    assign bus.ext_out_port  = fifo_head[ENTRY_W-1:DATA_W];
    assign bus.ext_out_data  = fifo_head[DATA_W-1:0];
    assign bus.out_count     = fifo_count;

    // IN path: the external write is ordered after the read-clear so it wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NPORTS; i++) in_reg[i] <= '0;
            fresh <= '0;
        end else begin
            if (bus.port_read) fresh[bus.port_addr] <= 1'b0;
            if (bus.ext_in_valid) begin
                in_reg[bus.ext_in_port] <= bus.ext_in_data;
                fresh[bus.ext_in_port]  <= 1'b1;
            end
        end
    end

    assign bus.port_rdata = bus.port_read ? in_reg[bus.port_addr] : '0;
    assign bus.in_fresh   = fresh;

endmodule

// File: tb/tb_io_port_unit.sv
// Scoreboard bench for io_port_unit: OUT entries are modelled in a queue.
module tb_io_port_unit;
    import io_port_pkg::*;

    logic clk;
    logic reset;
    int   n_total;
    int   n_bad;
    bit   mon_en;
    out_entry_t exp_q[$];

    io_port_if #(.DW(DATA_W), .AW(PORT_ADDR_W), .NPORTS(NUM_PORTS), .CNT_W(OUT_CNT_W)) bus ();

    io_port_unit #(
        .DATA_W         (DATA_W),
        .PORT_ADDR_W    (PORT_ADDR_W),
        .OUT_FIFO_DEPTH (OUT_FIFO_DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        bus.ext_out_ready = 1'b1;
        for (int i = 0; i < budget && bus.ext_out_valid; i++) tick();
        check_eq("drain_empty", 32'(bus.ext_out_valid), 32'd0);
    endtask

    // Model of the OUT queue, evaluated mid-cycle when inputs are stable.
    always @(negedge clk) begin
        int m;
        out_entry_t e;
        if (!reset) begin
            exp_q.delete();
        end else if (mon_en) begin
            m = exp_q.size();
            check_eq("out_count", 32'(bus.out_count), 32'(m));
            check_eq("out_valid", 32'(bus.ext_out_valid), 32'(m != 0));
            check_eq("stall", 32'(bus.port_stall), 32'(bus.port_write && m == OUT_FIFO_DEPTH));
            if (m != 0 && bus.ext_out_ready) begin
                e = exp_q.pop_front();
                check_eq("head", 32'({bus.ext_out_port, bus.ext_out_data}), 32'(e));
            end
            if (bus.port_write && m < OUT_FIFO_DEPTH) begin
                e.port = bus.port_addr;
                e.data = bus.port_wdata;
                exp_q.push_back(e);
            end
        end
    end

    initial begin
        n_total = 0;
        n_bad   = 0;
        mon_en  = 1'b0;
        reset   = 1'b0;
        bus.port_write = 1'b0;  bus.port_read = 1'b0;
        bus.port_addr  = '0;    bus.port_wdata = '0;
        bus.ext_out_ready = 1'b0;
        bus.ext_in_valid  = 1'b0; bus.ext_in_port = '0; bus.ext_in_data = '0;
        #2;
        check_eq("rst_count", 32'(bus.out_count), 32'd0);
        check_eq("rst_valid", 32'(bus.ext_out_valid), 32'd0);
        check_eq("rst_port", 32'(bus.ext_out_port), 32'd0);
        check_eq("rst_data", 32'(bus.ext_out_data), 32'd0);
        check_eq("rst_fresh", 32'(bus.in_fresh), 32'd0);
        check_eq("rst_stall", 32'(bus.port_stall), 32'd0);
        tick();
        tick();
        reset  = 1'b1;
        mon_en = 1'b1;
        tick();

        // Single OUT held by a stalled consumer.
        bus.port_write = 1'b1; bus.port_addr = 4'd3; bus.port_wdata = 16'hBEEF;
        tick();
        bus.port_write = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_eq("hold_valid", 32'(bus.ext_out_valid), 32'd1);
            check_eq("hold_port", 32'(bus.ext_out_port), 32'd3);
            check_eq("hold_data", 32'(bus.ext_out_data), 32'hBEEF);
            tick();
        end
        bus.ext_out_ready = 1'b1;
        tick();
        check_eq("pop_valid", 32'(bus.ext_out_valid), 32'd0);
        check_eq("pop_count", 32'(bus.out_count), 32'd0);
        bus.ext_out_ready = 1'b0;

        // Fill to full, stall the fifth, release with a pop.
        for (int k = 1; k <= 4; k++) begin
            bus.port_write = 1'b1; bus.port_addr = 4'(k); bus.port_wdata = 16'(k);
            tick();
        end
        bus.port_addr = 4'd5; bus.port_wdata = 16'd5;
        #1;
        check_eq("full_stall", 32'(bus.port_stall), 32'd1);
        tick();
        tick();
        check_eq("full_stall_held", 32'(bus.port_stall), 32'd1);
        check_eq("full_count", 32'(bus.out_count), 32'(OUT_FIFO_DEPTH));
        bus.ext_out_ready = 1'b1;
        tick();
        check_eq("stall_release", 32'(bus.port_stall), 32'd0);
        tick();
        bus.port_write = 1'b0;
        drain(20);
        bus.ext_out_ready = 1'b0;

        // Steady push+pop at count 2 walks the pointers through a wrap.
        for (int k = 0; k < 2; k++) begin
            bus.port_write = 1'b1; bus.port_addr = 4'(8 + k); bus.port_wdata = 16'h0040 + 16'(k);
            tick();
        end
        bus.ext_out_ready = 1'b1;
        for (int k = 2; k < 8; k++) begin
            bus.port_addr = 4'(8 + k); bus.port_wdata = 16'h0040 + 16'(k);
            tick();
            check_eq("steady_count", 32'(bus.out_count), 32'd2);
        end
        bus.port_write = 1'b0;
        drain(20);
        bus.ext_out_ready = 1'b0;

        // IN path: deposit, read, fresh flag clears.
        bus.ext_in_valid = 1'b1; bus.ext_in_port = 4'd7; bus.ext_in_data = 16'h1234;
        tick();
        bus.ext_in_valid = 1'b0;
        bus.port_addr = 4'd7;
        #1;
        check_eq("rdata_idle", 32'(bus.port_rdata), 32'd0);
        check_eq("fresh7_set", 32'(bus.in_fresh), 32'h0080);
        bus.port_read = 1'b1;
        #1;
        check_eq("rdata7", 32'(bus.port_rdata), 32'h1234);
        tick();
        bus.port_read = 1'b0;
        check_eq("fresh7_clr", 32'(bus.in_fresh), 32'h0000);

        // Same-port read and external write: old value seen, write wins fresh.
        bus.ext_in_valid = 1'b1; bus.ext_in_port = 4'd9; bus.ext_in_data = 16'h00AA;
        tick();
        bus.ext_in_data = 16'h0055;
        bus.port_read = 1'b1; bus.port_addr = 4'd9;
        #1;
        check_eq("rdata9_old", 32'(bus.port_rdata), 32'h00AA);
        tick();
        bus.ext_in_valid = 1'b0;
        check_eq("rdata9_new", 32'(bus.port_rdata), 32'h0055);
        check_eq("fresh9_set", 32'(bus.in_fresh), 32'h0200);
        tick();
        check_eq("fresh9_clr", 32'(bus.in_fresh), 32'h0000);

        // Different ports read and written together.
        bus.port_addr = 4'd7;
        bus.ext_in_valid = 1'b1; bus.ext_in_port = 4'd2; bus.ext_in_data = 16'hC0DE;
        #1;
        check_eq("rdata7_again", 32'(bus.port_rdata), 32'h1234);
        tick();
        bus.ext_in_valid = 1'b0;
        bus.port_read = 1'b0;
        check_eq("fresh2_only", 32'(bus.in_fresh), 32'h0004);

        // Asynchronous reset with two entries queued.
        for (int k = 0; k < 2; k++) begin
            bus.port_write = 1'b1; bus.port_addr = 4'(k); bus.port_wdata = 16'h0A00 + 16'(k);
            tick();
        end
        bus.port_write = 1'b0;
        check_eq("pre_rst_count", 32'(bus.out_count), 32'd2);
        reset = 1'b0;
        bus.port_read = 1'b1; bus.port_addr = 4'd7;
        #1;
        check_eq("arst_count", 32'(bus.out_count), 32'd0);
        check_eq("arst_valid", 32'(bus.ext_out_valid), 32'd0);
        check_eq("arst_data", 32'(bus.ext_out_data), 32'd0);
        check_eq("arst_fresh", 32'(bus.in_fresh), 32'd0);
        check_eq("arst_rdata", 32'(bus.port_rdata), 32'd0);
        tick();
        reset = 1'b1;
        bus.port_read = 1'b0;
        tick();

        // Queue still works after reset.
        bus.port_write = 1'b1; bus.port_addr = 4'hF; bus.port_wdata = 16'h5A5A;
        tick();
        bus.port_write = 1'b0;
        check_eq("post_rst_data", 32'(bus.ext_out_data), 32'h5A5A);
        drain(10);
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/io_port_unit.md
Name: io_port_unit

Overview:
Device-side responder for the processor's I/O port interface. The MEM stage's port reads and writes land here.
- CPU writes (OUT) are queued in a small FIFO and handed to the external world over a valid/ready handshake.
- External producers deposit data into 16 input-port registers, which the CPU reads combinationally (IN).
- The unit stalls the pipeline when the output queue cannot accept a write.

Parameters:
DATA_W, 16, port data width
PORT_ADDR_W, 4, port address width (16 ports)
OUT_FIFO_DEPTH, 4, output queue entries; power of two, >= 2

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
port_write  in  1  CPU OUT request this cycle
port_read  in  1  CPU IN request this cycle
port_addr  in  PORT_ADDR_W  port number for read or write
port_wdata  in  DATA_W  OUT data (already forwarded by MEM)
port_rdata  out  DATA_W  IN data, combinational
port_stall  out  1  hold pipeline; OUT not accepted this cycle
in_fresh  out  16  per-port "unread new data" flags
ext_out_valid  out  1  head of output queue valid
ext_out_port  out  PORT_ADDR_W  port number of head entry
ext_out_data  out  DATA_W  data of head entry
ext_out_ready  in  1  external consumer accepts head
ext_in_valid  in  1  external producer writes an input port
ext_in_port  in  PORT_ADDR_W  target input port
ext_in_data  in  DATA_W  data for input port
out_count  out  clog2(OUT_FIFO_DEPTH)+1  entries in output queue

Behaviour:
- Reset (reset=0, async): all 16 input registers = 0, in_fresh = 0, FIFO pointers and count = 0, ext_out_valid = 0, ext_out_port/ext_out_data = 0, port_stall = 0. Mid-operation reset discards queued entries immediately.
- OUT path:
  - Push occurs when port_write=1 and count < DEPTH. Entry {port_addr, port_wdata} is written at the clock edge.
  - Latency: the entry is visible on ext_out_* the cycle after the push if the queue was empty.
  - port_stall = port_write & full. This is combinational and takes no account of a same-cycle pop, so no pass-through. The CPU holds the request; the write is accepted in the first cycle the queue is not full.
  - Pop occurs when ext_out_valid & ext_out_ready; the head advances at the edge.
  - ext_out_valid = (count != 0). ext_out_port and ext_out_data are stable while valid=1 and ready=0.
  - Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both take effect.
  - Pointers wrap modulo DEPTH.
  - port_write=1 and port_read=1 in the same cycle is illegal from MEM. If it occurs, both actions are performed.
- IN path:
  - port_rdata = in_reg[port_addr] when port_read=1, else 0.
  - A read clears in_fresh[port_addr] at the edge.
  - When ext_in_valid=1, in_reg[ext_in_port] <= ext_in_data and in_fresh[ext_in_port] <= 1 at the edge. There is no ready; input is always accepted.
  - Simultaneous CPU read and external write to the same port: the CPU sees the old value combinationally, the register takes the new value, and in_fresh ends set (the write wins over the clear).
  - A different port being read and written in the same cycle: both proceed independently.
- out_count tracks occupancy 0..DEPTH exactly. It never exceeds DEPTH and never underflows, because a pop requires valid.

Decomposition:
- Shared package io_port_pkg: DATA_W, PORT_ADDR_W, NUM_PORTS=16, and the out-entry layout {port[3:0], data[15:0]} as a 20-bit packed constant/typedef.
- One sub-module: port_out_fifo, a synchronous FIFO with async active-low reset, push/pop/full/empty/count.
- The input register file and fresh flags stay inline.

Test Plan:
1. Reset pulse low mid-queue (2 entries held) -> out_count=0, ext_out_valid=0, in_fresh=16'h0000, port_rdata=0 on any read, all immediately on reset assertion.
2. OUT port 3 data 16'hBEEF with ext_out_ready=0 -> next cycle ext_out_valid=1, port=3, data=16'hBEEF, stable for 5 cycles; raise ready -> valid drops the following cycle, out_count=0.
3. Five back-to-back OUTs (data 1..5) with ready=0 -> four accepted, port_stall=1 on the fifth; raise ready -> stall drops the cycle after the first pop, and data emerges in order 1,2,3,4,5.
4. With count=2, hold push and pop active for 6 cycles -> out_count stays 2, pointers wrap, and output order matches input order.
5. ext_in port 7 = 16'h1234 -> in_fresh[7]=1; IN port 7 -> port_rdata=16'h1234, in_fresh[7]=0 next cycle.
6. Same cycle: IN port 9 (holding 16'h00AA) and ext_in port 9 = 16'h0055 -> port_rdata=16'h00AA that cycle, next cycle register=16'h0055 and in_fresh[9]=1.
